// File: rtl/prob_seq_bool_lut_if.sv
//----------------------------------------------------------------------------
// prob_seq_bool_lut_if : config, input and result handshakes of the LUT block
// Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

interface prob_seq_bool_lut_if #(
  parameter int NINPUTS = 2
);
  logic               cfg_start;
  logic               cfg_val;
  logic               cfg_bit;
  logic               busy;
  logic               in_val;
  logic               in_rdy;
  logic [NINPUTS-1:0] in_x;
  logic               out_val;
  logic               out_rdy;
  logic               out_f;

  modport master (
    output cfg_start, cfg_val, cfg_bit, in_val, in_x, out_rdy,
    input  busy, in_rdy, out_val, out_f
  );

  modport slave (
    input  cfg_start, cfg_val, cfg_bit, in_val, in_x, out_rdy,
    output busy, in_rdy, out_val, out_f
  );
endinterface

`default_nettype wire

// File: rtl/prob_seq_bool_lut.sv
//----------------------------------------------------------------------------
// prob_seq_bool_lut : serially loaded truth table, one-stage val/rdy evaluator
// Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module prob_seq_bool_lut #(
  parameter int                    NINPUTS     = 2,
  parameter logic [2**NINPUTS-1:0] RESET_TABLE = {1'b0, {(2**NINPUTS-1){1'b1}}}
) (
  input  wire logic             clk,
  input  wire logic             reset,
  prob_seq_bool_lut_if.slave    bus
);

  localparam int                 c_DEPTH    = 2**NINPUTS;
  localparam logic [NINPUTS:0]   c_LAST_IDX = (NINPUTS+1)'(c_DEPTH - 1);
  localparam logic [NINPUTS:0]   c_CNT_ONE  = (NINPUTS+1)'(1);

  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_LOAD = 1'b1;

  logic [0:0]         state_q,  state_d;
  logic [NINPUTS:0]   cnt_q,    cnt_d;
  logic [c_DEPTH-1:0] shadow_q, shadow_d;
  logic [c_DEPTH-1:0] active_q, active_d;
  logic               out_val_q, out_val_d;
  logic               out_f_q,   out_f_d;

  logic               w_in_rdy;
  logic               w_busy;
  logic               w_accept;

  // State register: FSM state plus the table storage it governs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_RUN;
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= RESET_TABLE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    case (state_q)
      S_RUN: begin
        if (bus.cfg_start) begin
          state_d  = S_LOAD;
          cnt_d    = '0;
          shadow_d = '0;
        end
      end
      S_LOAD: begin
        if (bus.cfg_start) begin
          cnt_d    = '0;
          shadow_d = '0;
        end else if (bus.cfg_val) begin
          shadow_d[cnt_q[NINPUTS-1:0]] = bus.cfg_bit;
          cnt_d                        = cnt_q + c_CNT_ONE;
          // Final bit commits the whole shadow, including itself, this edge
          if (cnt_q == c_LAST_IDX) begin
            active_d = shadow_d;
            state_d  = S_RUN;
          end
        end
      end
      default: begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    w_busy   = (state_q == S_LOAD);
    w_in_rdy = (state_q == S_RUN) && (!out_val_q || bus.out_rdy);
    w_accept = bus.in_val && w_in_rdy;
  end

  always_comb begin
    out_val_d = out_val_q;
    out_f_d   = out_f_q;
    if (w_accept) begin
      out_val_d = 1'b1;
      out_f_d   = active_q[bus.in_x];
    end else if (bus.out_rdy) begin
      out_val_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_val_q <= 1'b0;
      out_f_q   <= 1'b0;
    end else begin
      out_val_q <= out_val_d;
      out_f_q   <= out_f_d;
    end
  end

  assign bus.busy    = w_busy;
  assign bus.in_rdy  = w_in_rdy;
  assign bus.out_val = out_val_q;
  assign bus.out_f   = out_f_q;

endmodule

`default_nettype wire

// File: tb/tb_prob_seq_bool_lut.sv
//----------------------------------------------------------------------------
// tb_prob_seq_bool_lut : scoreboard bench for NINPUTS=2 and NINPUTS=3 builds
// Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_prob_seq_bool_lut;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  prob_seq_bool_lut_if #(.NINPUTS(2)) b2 ();
  prob_seq_bool_lut_if #(.NINPUTS(3)) b3 ();

  prob_seq_bool_lut #(.NINPUTS(2)) dut2 (.clk(clk), .reset(reset), .bus(b2));
  prob_seq_bool_lut #(.NINPUTS(3)) dut3 (.clk(clk), .reset(reset), .bus(b3));

  int   checks = 0;
  int   errors = 0;
  logic q2[$];
  logic q3[$];
  logic [3:0] model2 = 4'b0111;
  logic [7:0] model3 = 8'h7F;
  bit   prev2 = 1'b0;
  bit   prev3 = 1'b0;

  // One clock: score pre-edge handshakes, then advance to edge+1
  task automatic cycle();
    logic e;
    #1;
    if (prev2) begin
      checks++;
      if (b2.out_val !== 1'b1) begin errors++; $display("FAIL lat2 out_val=%b exp=1", b2.out_val); end
    end
    if (b2.out_val === 1'b1 && b2.out_rdy === 1'b1) begin
      checks++;
      if (q2.size() == 0) begin
        errors++; $display("FAIL sb2_extra out_f=%b exp=none", b2.out_f);
      end else begin
        e = q2.pop_front();
        if (b2.out_f !== e) begin errors++; $display("FAIL sb2 out_f=%b exp=%b", b2.out_f, e); end
      end
    end
    prev2 = (b2.in_val === 1'b1 && b2.in_rdy === 1'b1);
    if (prev2) q2.push_back(model2[b2.in_x]);

    if (prev3) begin
      checks++;
      if (b3.out_val !== 1'b1) begin errors++; $display("FAIL lat3 out_val=%b exp=1", b3.out_val); end
    end
    if (b3.out_val === 1'b1 && b3.out_rdy === 1'b1) begin
      checks++;
      if (q3.size() == 0) begin
        errors++; $display("FAIL sb3_extra out_f=%b exp=none", b3.out_f);
      end else begin
        e = q3.pop_front();
        if (b3.out_f !== e) begin errors++; $display("FAIL sb3 out_f=%b exp=%b", b3.out_f, e); end
      end
    end
    prev3 = (b3.in_val === 1'b1 && b3.in_rdy === 1'b1);
    if (prev3) q3.push_back(model3[b3.in_x]);
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input bit sel3, input logic s, input logic v, input logic b);
    if (sel3) begin b3.cfg_start = s; b3.cfg_val = v; b3.cfg_bit = b; end
    else      begin b2.cfg_start = s; b2.cfg_val = v; b2.cfg_bit = b; end
  endtask

  task automatic do_load(input bit sel3, input logic [7:0] tbl, input int n, input bit present);
    logic bsy, rdy;
    set_cfg(sel3, 1'b1, 1'b0, 1'b0);
    cycle();
    if (present) begin
      if (sel3) b3.in_val = 1'b1; else b2.in_val = 1'b1;
    end
    for (int k = 0; k < n; k++) begin
      set_cfg(sel3, 1'b0, 1'b1, tbl[k]);
      #1;
      bsy = sel3 ? b3.busy : b2.busy;
      rdy = sel3 ? b3.in_rdy : b2.in_rdy;
      checks++;
      if (bsy !== 1'b1 || rdy !== 1'b0) begin
        errors++; $display("FAIL load_busy k=%0d busy=%b in_rdy=%b exp=1/0", k, bsy, rdy);
      end
      cycle();
    end
    set_cfg(sel3, 1'b0, 1'b0, 1'b0);
    #1;
    bsy = sel3 ? b3.busy : b2.busy;
    checks++;
    if (bsy !== 1'b0) begin errors++; $display("FAIL load_done busy=%b exp=0", bsy); end
    if (sel3) model3 = tbl; else model2 = tbl[3:0];
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (b2.busy !== 1'b0 || b2.in_rdy !== 1'b1 || b2.out_val !== 1'b0 || b2.out_f !== 1'b0) begin
      errors++; $display("FAIL reset2 busy/rdy/val/f=%b%b%b%b exp=0100", b2.busy, b2.in_rdy, b2.out_val, b2.out_f);
    end
    checks++;
    if (b3.busy !== 1'b0 || b3.in_rdy !== 1'b1 || b3.out_val !== 1'b0 || b3.out_f !== 1'b0) begin
      errors++; $display("FAIL reset3 busy/rdy/val/f=%b%b%b%b exp=0100", b3.busy, b3.in_rdy, b3.out_val, b3.out_f);
    end
    reset = 1'b0;
  endtask

  task automatic test_reset_table();
    b2.out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b2.in_val = 1'b1; b2.in_x = 2'(i);
      #1;
      checks++;
      if (b2.in_rdy !== 1'b1) begin errors++; $display("FAIL nand_rdy i=%0d in_rdy=%b exp=1", i, b2.in_rdy); end
      cycle();
    end
    b2.in_val = 1'b0;
    cycle();
  endtask

  task automatic test_cfg_ignored();
    set_cfg(1'b0, 1'b0, 1'b1, 1'b0);
    cycle();
    set_cfg(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (b2.busy !== 1'b0) begin errors++; $display("FAIL cfg_ignored busy=%b exp=0", b2.busy); end
  endtask

  task automatic test_load_xor();
    b2.in_x = 2'd1;
    do_load(1'b0, 8'h06, 4, 1'b1);
    checks++;
    if (b2.in_rdy !== 1'b1) begin errors++; $display("FAIL commit_rdy in_rdy=%b exp=1", b2.in_rdy); end
    cycle();
    for (int i = 0; i < 4; i++) begin
      b2.in_x = 2'(i);
      cycle();
    end
    b2.in_val = 1'b0;
    cycle();
  endtask

  task automatic test_backpressure();
    b2.out_rdy = 1'b0; b2.in_val = 1'b1; b2.in_x = 2'd3;
    cycle();
    b2.in_x = 2'd1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (b2.out_val !== 1'b1 || b2.out_f !== 1'b0 || b2.in_rdy !== 1'b0) begin
        errors++; $display("FAIL bp_hold val/f/rdy=%b%b%b exp=100", b2.out_val, b2.out_f, b2.in_rdy);
      end
      cycle();
    end
    b2.out_rdy = 1'b1;
    #1;
    checks++;
    if (b2.in_rdy !== 1'b1) begin errors++; $display("FAIL bp_release in_rdy=%b exp=1", b2.in_rdy); end
    cycle();
    b2.in_val = 1'b0;
    cycle();
  endtask

  task automatic test_restart();
    set_cfg(1'b0, 1'b1, 1'b0, 1'b0); cycle();
    set_cfg(1'b0, 1'b0, 1'b1, 1'b1); cycle(); cycle();
    set_cfg(1'b0, 1'b1, 1'b1, 1'b1); cycle();
    for (int k = 0; k < 4; k++) begin
      set_cfg(1'b0, 1'b0, 1'b1, (k == 3) ? 1'b1 : 1'b0);
      cycle();
      if (k == 2) begin
        checks++;
        if (b2.busy !== 1'b1) begin errors++; $display("FAIL restart_busy busy=%b exp=1", b2.busy); end
      end
    end
    set_cfg(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (b2.busy !== 1'b0) begin errors++; $display("FAIL restart_commit busy=%b exp=0", b2.busy); end
    model2 = 4'b1000;
    b2.in_val = 1'b1; b2.in_x = 2'd3; cycle();
    b2.in_x = 2'd2; cycle();
    b2.in_val = 1'b0; cycle();
  endtask

  task automatic test_reset_mid_load();
    b2.out_rdy = 1'b0; b2.in_val = 1'b1; b2.in_x = 2'd0;
    cycle();
    b2.in_val = 1'b0;
    set_cfg(1'b0, 1'b1, 1'b0, 1'b0); cycle();
    set_cfg(1'b0, 1'b0, 1'b1, 1'b0); cycle();
    set_cfg(1'b0, 1'b0, 1'b1, 1'b1); cycle();
    set_cfg(1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (b2.busy !== 1'b0 || b2.out_val !== 1'b0 || b2.in_rdy !== 1'b1) begin
      errors++; $display("FAIL midload_reset busy/val/rdy=%b%b%b exp=001", b2.busy, b2.out_val, b2.in_rdy);
    end
    q2.delete(); q3.delete(); prev2 = 1'b0; prev3 = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model2 = 4'b0111; model3 = 8'h7F;
    b2.out_rdy = 1'b1; b2.in_val = 1'b1; b2.in_x = 2'd3; cycle();
    b2.in_x = 2'd0; cycle();
    b2.in_val = 1'b0; cycle();
  endtask

  task automatic test_n3_parity();
    b3.out_rdy = 1'b0; b3.in_val = 1'b1; b3.in_x = 3'd7;
    cycle();
    b3.in_val = 1'b0;
    do_load(1'b1, 8'b1001_0110, 8, 1'b0);
    checks++;
    if (b3.out_val !== 1'b1 || b3.out_f !== 1'b0) begin
      errors++; $display("FAIL n3_held val/f=%b%b exp=10", b3.out_val, b3.out_f);
    end
    b3.out_rdy = 1'b1; b3.in_val = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b3.in_x = 3'(i);
      cycle();
    end
    b3.in_val = 1'b0;
    cycle();
  endtask

  initial begin
    reset = 1'b1;
    b2.cfg_start = 1'b0; b2.cfg_val = 1'b0; b2.cfg_bit = 1'b0;
    b2.in_val = 1'b0; b2.in_x = '0; b2.out_rdy = 1'b0;
    b3.cfg_start = 1'b0; b3.cfg_val = 1'b0; b3.cfg_bit = 1'b0;
    b3.in_val = 1'b0; b3.in_x = '0; b3.out_rdy = 1'b0;
    test_reset();
    test_reset_table();
    test_cfg_ignored();
    test_load_xor();
    test_backpressure();
    test_restart();
    test_reset_mid_load();
    test_n3_parity();
    checks++;
    if (q2.size() != 0 || q3.size() != 0) begin
      errors++; $display("FAIL sb_drain left2=%0d left3=%0d exp=0/0", q2.size(), q3.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
